// File: rtl/rggen_axi4lite_bus_bridge_pkg.sv
// rggen_axi4lite_bus_bridge_pkg: shared widths, access/response codes and FSM states for the AXI4-Lite bridge
package rggen_axi4lite_bus_bridge_pkg;
  function automatic int rggen_clip_width(int w);
    return (w < 1) ? 1 : w;
  endfunction
  localparam logic [1:0] RGGEN_READ = 2'b00;
  localparam logic [1:0] RGGEN_WRITE = 2'b01;
  localparam logic [1:0] RGGEN_OKAY = 2'b00;
  localparam logic [1:0] RGGEN_EXOKAY = 2'b01;
  localparam logic [1:0] RGGEN_SLVERR = 2'b10;
  localparam logic [1:0] RGGEN_DECERR = 2'b11;
  typedef enum logic [1:0] {
    IDLE,
    BUS_ACCESS,
    RESPONSE
  } state_e;
endpackage

// File: rtl/rggen_axi4lite_bus_bridge.sv
// rggen_axi4lite_bus_bridge: one-at-a-time AXI4-Lite to rggen register bus bridge
module rggen_axi4lite_bus_bridge
  import rggen_axi4lite_bus_bridge_pkg::*;
#(
  parameter int ID_WIDTH = 0,
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH = 32,
  parameter bit WRITE_FIRST = 1'b1,
  parameter int ACTUAL_ID_WIDTH = rggen_clip_width(ID_WIDTH)
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_awvalid,
  output logic                       o_awready,
  input  logic [ACTUAL_ID_WIDTH-1:0] i_awid,
  input  logic [ADDRESS_WIDTH-1:0]   i_awaddr,
  input  logic [2:0]                 i_awprot,
  input  logic                       i_wvalid,
  output logic                       o_wready,
  input  logic [BUS_WIDTH-1:0]       i_wdata,
  input  logic [BUS_WIDTH/8-1:0]     i_wstrb,
  output logic                       o_bvalid,
  input  logic                       i_bready,
  output logic [ACTUAL_ID_WIDTH-1:0] o_bid,
  output logic [1:0]                 o_bresp,
  input  logic                       i_arvalid,
  output logic                       o_arready,
  input  logic [ACTUAL_ID_WIDTH-1:0] i_arid,
  input  logic [ADDRESS_WIDTH-1:0]   i_araddr,
  input  logic [2:0]                 i_arprot,
  output logic                       o_rvalid,
  input  logic                       i_rready,
  output logic [ACTUAL_ID_WIDTH-1:0] o_rid,
  output logic [1:0]                 o_rresp,
  output logic [BUS_WIDTH-1:0]       o_rdata,
  output logic                       o_bus_valid,
  output logic [1:0]                 o_bus_access,
  output logic [ADDRESS_WIDTH-1:0]   o_bus_address,
  output logic [BUS_WIDTH-1:0]       o_bus_write_data,
  output logic [BUS_WIDTH/8-1:0]     o_bus_strobe,
  input  logic                       i_bus_ready,
  input  logic [1:0]                 i_bus_status,
  input  logic [BUS_WIDTH-1:0]       i_bus_read_data
);
  localparam int STRB_W = BUS_WIDTH / 8;
  localparam int LSB = $clog2(STRB_W);
  state_e state_q, state_d;
  logic write_go, read_go, resp_ack, unused_prot;
  logic [ADDRESS_WIDTH-1:0] addr_in;
  logic [1:0] access_q, resp_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [BUS_WIDTH-1:0] wdata_q, rdata_q;
  logic [STRB_W-1:0] strb_q;
  logic [ACTUAL_ID_WIDTH-1:0] id_q;
  assign unused_prot = ^{i_awprot, i_arprot};
  always_comb begin
    write_go = state_q == IDLE && i_awvalid && i_wvalid && (WRITE_FIRST || !i_arvalid);
    read_go = state_q == IDLE && i_arvalid && !write_go;
    resp_ack = access_q == RGGEN_WRITE ? i_bready : i_rready;
    addr_in = write_go ? i_awaddr : i_araddr;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       state_d = (write_go || read_go) ? BUS_ACCESS : IDLE;
      BUS_ACCESS: state_d = i_bus_ready ? RESPONSE : BUS_ACCESS;
      RESPONSE:   state_d = resp_ack ? IDLE : RESPONSE;
      default:    state_d = IDLE;
    endcase
  end
  // rdata is only sampled on reads so write-cycle garbage never reaches o_rdata
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      access_q <= RGGEN_READ;
      addr_q <= '0;
      wdata_q <= '0;
      strb_q <= '0;
      id_q <= '0;
      resp_q <= '0;
      rdata_q <= '0;
    end else begin
      if (write_go || read_go) begin
        access_q <= write_go ? RGGEN_WRITE : RGGEN_READ;
        addr_q <= {addr_in[ADDRESS_WIDTH-1:LSB], LSB'(0)};
        wdata_q <= write_go ? i_wdata : '0;
        strb_q <= write_go ? i_wstrb : '1;
        id_q <= write_go ? i_awid : i_arid;
      end
      if (state_q == BUS_ACCESS && i_bus_ready) begin
        resp_q <= i_bus_status;
        if (access_q == RGGEN_READ) rdata_q <= i_bus_read_data;
      end
    end
  end
  always_comb begin
    o_awready = write_go;
    o_wready = write_go;
    o_arready = read_go;
    o_bus_valid = state_q == BUS_ACCESS;
    o_bus_access = access_q;
    o_bus_address = addr_q;
    o_bus_write_data = wdata_q;
    o_bus_strobe = strb_q;
    o_bvalid = state_q == RESPONSE && access_q == RGGEN_WRITE;
    o_rvalid = state_q == RESPONSE && access_q == RGGEN_READ;
    o_bid = id_q;
    o_rid = id_q;
    o_bresp = resp_q;
    o_rresp = resp_q;
    o_rdata = rdata_q;
  end
endmodule

// File: tb/tb_rggen_axi4lite_bus_bridge.sv
// tb_rggen_axi4lite_bus_bridge: table-driven and directed checks; unit 0 is write-first, unit 1 read-first
module tb_rggen_axi4lite_bus_bridge;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int IW = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [1:0] awv, wv, arv;
  logic [IW-1:0] awid, arid;
  logic [AW-1:0] awaddr, araddr;
  logic [DW-1:0] wdata, bus_rdata;
  logic [3:0] wstrb;
  logic bready, rready, bus_ready;
  logic [1:0] bus_status;
  logic [1:0] awready, wready, arready, bvalid, rvalid, bus_valid;
  logic [IW-1:0] bid [2];
  logic [IW-1:0] rid [2];
  logic [1:0] bresp [2];
  logic [1:0] rresp [2];
  logic [1:0] bus_access [2];
  logic [DW-1:0] rdata_o [2];
  logic [DW-1:0] bus_wdata [2];
  logic [AW-1:0] bus_addr [2];
  logic [3:0] bus_strb [2];
  int checks = 0;
  int failures = 0;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    rggen_axi4lite_bus_bridge #(
      .ID_WIDTH(IW), .ADDRESS_WIDTH(AW), .BUS_WIDTH(DW), .WRITE_FIRST(g == 0)
    ) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_awvalid(awv[g]), .o_awready(awready[g]), .i_awid(awid), .i_awaddr(awaddr), .i_awprot(3'b000),
      .i_wvalid(wv[g]), .o_wready(wready[g]), .i_wdata(wdata), .i_wstrb(wstrb),
      .o_bvalid(bvalid[g]), .i_bready(bready), .o_bid(bid[g]), .o_bresp(bresp[g]),
      .i_arvalid(arv[g]), .o_arready(arready[g]), .i_arid(arid), .i_araddr(araddr), .i_arprot(3'b000),
      .o_rvalid(rvalid[g]), .i_rready(rready), .o_rid(rid[g]), .o_rresp(rresp[g]), .o_rdata(rdata_o[g]),
      .o_bus_valid(bus_valid[g]), .o_bus_access(bus_access[g]), .o_bus_address(bus_addr[g]),
      .o_bus_write_data(bus_wdata[g]), .o_bus_strobe(bus_strb[g]),
      .i_bus_ready(bus_ready), .i_bus_status(bus_status), .i_bus_read_data(bus_rdata)
    );
  end
  typedef struct {
    logic wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [3:0] strb;
    logic [IW-1:0] id;
    int wait_n;
    logic [1:0] status;
    logic [DW-1:0] rdata;
    logic [AW-1:0] exp_addr;
    logic [3:0] exp_strb;
    logic [DW-1:0] exp_wdata;
    logic [DW-1:0] exp_rdata;
  } vec_t;
  vec_t tbl [5];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic set_valid(input logic aw, input logic w, input logic ar);
    awv = {2{aw}};
    wv = {2{w}};
    arv = {2{ar}};
  endtask
  task automatic finish_txn(input logic [1:0] st, input logic [DW-1:0] rd);
    bus_ready = 1'b1;
    bus_status = st;
    bus_rdata = rd;
    step();
    bus_ready = 1'b0;
    bready = 1'b1;
    rready = 1'b1;
    step();
    bready = 1'b0;
    rready = 1'b0;
  endtask
  task automatic txn(input vec_t v);
    awid = v.id;
    arid = v.id;
    awaddr = v.addr;
    araddr = v.addr;
    wdata = v.data;
    wstrb = v.strb;
    set_valid(v.wr, v.wr, !v.wr);
    #1;
    chk("accept_ready", v.wr ? awready[0] : arready[0], 1);
    step();
    set_valid(0, 0, 0);
    chk("bus_valid", bus_valid[0], 1);
    chk("bus_access", bus_access[0], v.wr ? 2'b01 : 2'b00);
    chk("bus_address", bus_addr[0], v.exp_addr);
    chk("bus_strobe", bus_strb[0], v.exp_strb);
    chk("bus_write_data", bus_wdata[0], v.exp_wdata);
    repeat (v.wait_n) begin
      step();
      chk("bus_hold_valid", bus_valid[0], 1);
      chk("bus_hold_address", bus_addr[0], v.exp_addr);
    end
    bus_ready = 1'b1;
    bus_status = v.status;
    bus_rdata = v.rdata;
    step();
    bus_ready = 1'b0;
    chk("bus_valid_drop", bus_valid[0], 0);
    chk("bvalid", bvalid[0], v.wr);
    chk("rvalid", rvalid[0], !v.wr);
    chk("resp_id", v.wr ? bid[0] : rid[0], v.id);
    chk("resp_code", v.wr ? bresp[0] : rresp[0], v.status);
    chk("rdata", rdata_o[0], v.exp_rdata);
    bready = 1'b1;
    rready = 1'b1;
    step();
    bready = 1'b0;
    rready = 1'b0;
    chk("resp_done", {bvalid[0], rvalid[0]}, 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    tbl[0] = '{1'b1, 8'h14, 32'hDEADBEEF, 4'hF, 4'h1, 2, 2'b00, 32'hFFFFFFFF, 8'h14, 4'hF, 32'hDEADBEEF, 32'h0};
    tbl[1] = '{1'b0, 8'h17, 32'h0, 4'h0, 4'h2, 0, 2'b10, 32'h00001234, 8'h14, 4'hF, 32'h0, 32'h00001234};
    tbl[2] = '{1'b1, 8'h3B, 32'hA5A50001, 4'h5, 4'h7, 1, 2'b11, 32'hFFFFFFFF, 8'h38, 4'h5, 32'hA5A50001, 32'h00001234};
    tbl[3] = '{1'b0, 8'hFF, 32'h0, 4'h0, 4'hF, 3, 2'b01, 32'hCAFEF00D, 8'hFC, 4'hF, 32'h0, 32'hCAFEF00D};
    tbl[4] = '{1'b1, 8'h00, 32'h0, 4'h0, 4'h0, 0, 2'b00, 32'h0BADF00D, 8'h00, 4'h0, 32'h0, 32'hCAFEF00D};
    set_valid(0, 0, 0);
    {awid, arid, awaddr, araddr, wdata, wstrb} = '0;
    {bready, rready, bus_ready, bus_status, bus_rdata} = '0;
    step();
    step();
    chk("rst_bus_valid", bus_valid, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata_o[0], 0);
    chk("rst_bid", bid[0], 0);
    chk("rst_bus_address", bus_addr[0], 0);
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 5; i++) txn(tbl[i]);
    // AW ahead of W: no ready until both present, then a single pulse
    awaddr = 8'h08;
    awid = 4'h5;
    wdata = 32'h11223344;
    wstrb = 4'h3;
    set_valid(1, 0, 0);
    repeat (3) begin
      #1;
      chk("offset_no_awready", {awready[0], wready[0]}, 0);
      step();
    end
    set_valid(1, 1, 0);
    #1;
    chk("offset_ready_pair", {awready[0], wready[0]}, 2'b11);
    step();
    chk("offset_ready_once", {awready[0], wready[0]}, 0);
    set_valid(0, 0, 0);
    chk("offset_bus_data", bus_wdata[0], 32'h11223344);
    finish_txn(2'b00, 32'h0);
    // simultaneous write and read requests
    awaddr = 8'h20;
    awid = 4'h3;
    araddr = 8'h30;
    arid = 4'h4;
    wdata = 32'h0;
    wstrb = 4'hF;
    set_valid(1, 1, 1);
    #1;
    chk("arb_wf_awready", awready[0], 1);
    chk("arb_wf_arready", arready[0], 0);
    chk("arb_rf_arready", arready[1], 1);
    chk("arb_rf_awready", awready[1], 0);
    step();
    chk("arb_wf_first_access", bus_access[0], 2'b01);
    chk("arb_rf_first_access", bus_access[1], 2'b00);
    awv = 2'b10;
    wv = 2'b10;
    arv = 2'b01;
    finish_txn(2'b00, 32'h0);
    #1;
    chk("arb_wf_second_arready", arready[0], 1);
    chk("arb_rf_second_awready", awready[1], 1);
    step();
    set_valid(0, 0, 0);
    chk("arb_wf_second_access", bus_access[0], 2'b00);
    chk("arb_rf_second_access", bus_access[1], 2'b01);
    finish_txn(2'b00, 32'h0);
    // read response stalled with new requests waiting
    araddr = 8'h44;
    arid = 4'h9;
    set_valid(0, 0, 1);
    step();
    set_valid(0, 0, 0);
    bus_ready = 1'b1;
    bus_status = 2'b00;
    bus_rdata = 32'h000055AA;
    step();
    bus_ready = 1'b0;
    set_valid(1, 1, 1);
    repeat (5) begin
      chk("bp_rvalid", rvalid[0], 1);
      chk("bp_rdata", rdata_o[0], 32'h000055AA);
      chk("bp_rid", rid[0], 4'h9);
      chk("bp_no_accept", {awready[0], arready[0]}, 0);
      step();
    end
    rready = 1'b1;
    #1;
    chk("bp_no_accept_on_handshake", {awready[0], arready[0]}, 0);
    step();
    rready = 1'b0;
    chk("bp_rvalid_drop", rvalid[0], 0);
    chk("bp_accept_after", awready[0], 1);
    step();
    set_valid(0, 0, 0);
    finish_txn(2'b00, 32'h0);
    // reset in the middle of a bus access
    awaddr = 8'h10;
    set_valid(1, 1, 0);
    step();
    set_valid(0, 0, 0);
    chk("rstmid_bus_valid_before", bus_valid[0], 1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_bus_valid", bus_valid, 0);
    chk("rstmid_resp_valid", {bvalid, rvalid}, 0);
    chk("rstmid_rdata", rdata_o[0], 0);
    step();
    rst_n = 1'b1;
    step();
    araddr = 8'h04;
    set_valid(0, 0, 1);
    #1;
    chk("rstmid_idle_arready", arready[0], 1);
    step();
    set_valid(0, 0, 0);
    chk("rstmid_read_access", bus_access[0], 2'b00);
    chk("rstmid_read_valid", bus_valid[0], 1);
    finish_txn(2'b00, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rggen_axi4lite_bus_bridge.md
Name: rggen_axi4lite_bus_bridge

Overview:
- Sits directly downstream of the AXI4-Lite skid buffer and consumes its AW/W/B/AR/R master-side channels.
- Converts each single-beat AXI4-Lite transaction into one access on the rggen internal register bus, then returns the B or R response.
- Serves one transaction at a time. Write/read arbitration is parameterised.

Parameters:
- ID_WIDTH, 0, AXI ID width; 0 means no ID.
- ADDRESS_WIDTH, 8, byte address width.
- BUS_WIDTH, 32, data width; must be 32 or 64.
- WRITE_FIRST, 1, 1 gives write priority and 0 gives read priority when AW+W and AR are valid in the same cycle.
- ACTUAL_ID_WIDTH, rggen_clip_width(ID_WIDTH), internal ID width; minimum 1.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_awvalid/o_awready  in/out  1  AW handshake
- i_awid  in  ACTUAL_ID_WIDTH  write ID
- i_awaddr  in  ADDRESS_WIDTH  write address
- i_awprot  in  3  ignored
- i_wvalid/o_wready  in/out  1  W handshake
- i_wdata  in  BUS_WIDTH  write data
- i_wstrb  in  BUS_WIDTH/8  byte strobes
- o_bvalid/i_bready  out/in  1  B handshake
- o_bid  out  ACTUAL_ID_WIDTH  write response ID
- o_bresp  out  2  write response
- i_arvalid/o_arready  in/out  1  AR handshake
- i_arid  in  ACTUAL_ID_WIDTH  read ID
- i_araddr  in  ADDRESS_WIDTH  read address
- i_arprot  in  3  ignored
- o_rvalid/i_rready  out/in  1  R handshake
- o_rid  out  ACTUAL_ID_WIDTH  read response ID
- o_rresp  out  2  read response
- o_rdata  out  BUS_WIDTH  read data
- o_bus_valid  out  1  register access request
- o_bus_access  out  2  access type: 00 read, 01 write
- o_bus_address  out  ADDRESS_WIDTH  word-aligned address
- o_bus_write_data  out  BUS_WIDTH  write data
- o_bus_strobe  out  BUS_WIDTH/8  byte strobes
- i_bus_ready  in  1  access complete
- i_bus_status  in  2  00 OKAY, 01 EXOKAY, 10 SLVERR, 11 DECERR
- i_bus_read_data  in  BUS_WIDTH  read data

Behaviour:
- Reset:
  - State returns to IDLE.
  - o_bus_valid, o_bvalid, o_rvalid = 0.
  - Captured address, data, strobe, ID, resp and rdata = 0.
  - Readies are combinational and therefore 0 outside IDLE.
  - Reset mid-access abandons the transaction with no response issued.
- States: IDLE -> BUS_ACCESS -> RESPONSE -> IDLE.
- IDLE:
  - write_go = i_awvalid && i_wvalid && (WRITE_FIRST || !i_arvalid).
  - read_go = i_arvalid && !write_go.
  - o_awready = o_wready = write_go. AW and W are accepted in the same cycle only; AW alone or W alone waits with no ready asserted.
  - o_arready = read_go.
- On accept, capture into registers and go to BUS_ACCESS:
  - address = addr with the low log2(BUS_WIDTH/8) bits cleared.
  - ID.
  - Access type.
  - Strobe: wstrb for writes, all ones for reads.
  - Write data; 0 for reads.
- BUS_ACCESS:
  - o_bus_valid = 1; all o_bus_* outputs are held stable until i_bus_ready.
  - i_bus_ready in the first BUS_ACCESS cycle is legal; there is no minimum wait.
  - On ready: capture i_bus_status into resp and i_bus_read_data into rdata (reads only), drop o_bus_valid, go to RESPONSE.
- RESPONSE:
  - Drive o_bvalid (write) or o_rvalid (read) with the captured ID and resp; o_rdata holds the captured data.
  - Hold until i_bready / i_rready, then go to IDLE the next cycle.
  - No new AW/W/AR is accepted in the same cycle as the response handshake.
- Latency: AXI accept to o_bus_valid is 1 cycle; bus ready to B/R valid is 1 cycle. Peak throughput is one transaction per 3 cycles.
- o_bid and o_rid are captured per transaction, never taken combinationally from the inputs.
- Response and bus-access transitions depend only on the current state; no overlap between transactions.
- X on i_bus_read_data during writes must not propagate; o_rdata stays at its last value.

Decomposition:
- Shared package/macro header holds:
  - rggen_clip_width macro.
  - Access-type constants: RGGEN_READ = 2'b00, RGGEN_WRITE = 2'b01.
  - Response constants: OKAY, EXOKAY, SLVERR, DECERR.
  - State encoding: IDLE, BUS_ACCESS, RESPONSE.
- Single flat module with no sub-module. The parent instantiates the skid buffer followed by this bridge.

Test Plan:
- Write of AW addr 0x14, W data 0xDEADBEEF, strb 0xF, id 1, with ready after 2 cycles:
  - o_bus_address = 0x14, access = 01, strobe = 0xF.
  - Then o_bvalid with bid = 1, bresp = 00.
- Read of addr 0x17 with status 10 and rdata 0x1234:
  - o_bus_address = 0x14, strobe = all ones.
  - o_rvalid with rresp = 10, rdata = 0x00001234.
- AW and W offset:
  - AW alone for 3 cycles gives no awready.
  - When W arrives, awready and wready pulse together exactly once.
- Arbitration: simultaneous AW+W and AR.
  - With WRITE_FIRST = 1 the write is served first, then the read.
  - With WRITE_FIRST = 0 the read is served first.
- Backpressure and reset:
  - i_rready held low 5 cycles: rvalid, rdata and rid stay stable and no new accept occurs.
  - Reset asserted during BUS_ACCESS: all valids are 0 immediately and state is IDLE after release.
